// File: rtl/spike_binner.sv
// rtl/spike_binner.sv - spike conditioning (sync, edge detect, refractory) and fixed-window spike binning
// Counts accepted spikes per BIN_CYCLES window and emits a one-cycle strobe with the saturated count.
module spike_binner #(
  parameter int BIN_CYCLES     = 5000000,
  parameter int REFRACT_CYCLES = 100,
  parameter int SYNC_STAGES    = 2,
  parameter int COUNT_MAX      = 32767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        spike_in,
  output logic        bin_strobe,
  output logic [15:0] bin_count,
  output logic        bin_sat
);

  localparam int WC_W = $clog2(BIN_CYCLES);
  localparam int RF_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BIN_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LOAD = RF_W'(REFRACT_CYCLES);
  localparam logic [15:0]     CNT_MAX = 16'(COUNT_MAX);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [1:0]             rst_pipe;
  logic                   rst_int;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;
  logic                   spike_edge;

  logic [0:0]      state;
  logic [WC_W-1:0] wc;
  logic [15:0]     acc;
  logic            sat;
  logic [RF_W-1:0] refr;

  logic            accept;
  logic            closing;
  logic            clip;
  logic [15:0]     acc_sum;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe[1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], spike_in};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  assign spike_edge = sync[SYNC_STAGES-1] & ~sync_d;

  assign accept  = (state == COUNT) && spike_edge && (refr == '0);
  assign closing = (state == COUNT) && (wc == WC_LAST);
  assign clip    = accept && (acc >= CNT_MAX);
  assign acc_sum = acc + {15'd0, accept};

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state      <= IDLE;
      wc         <= '0;
      acc        <= '0;
      sat        <= 1'b0;
      refr       <= '0;
      bin_strobe <= 1'b0;
      bin_count  <= '0;
      bin_sat    <= 1'b0;
    end else begin
      bin_strobe <= 1'b0;
      case (state)
        IDLE: begin
          wc   <= '0;
          acc  <= '0;
          sat  <= 1'b0;
          refr <= '0;
          if (enable) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          // Lockout keeps running across window boundaries.
          if (accept) begin
            refr <= RF_LOAD;
          end else if (refr != '0) begin
            refr <= refr - 1'b1;
          end
          if (closing) begin
            bin_strobe <= 1'b1;
            bin_count  <= clip ? CNT_MAX : acc_sum;
            bin_sat    <= sat | clip;
            acc        <= '0;
            sat        <= 1'b0;
            wc         <= '0;
            if (!enable) begin
              state <= IDLE;
            end
          end else if (!enable) begin
            state <= IDLE;
            wc    <= '0;
            acc   <= '0;
            sat   <= 1'b0;
          end else begin
            wc <= wc + 1'b1;
            if (accept) begin
              if (clip) begin
                sat <= 1'b1;
              end else begin
                acc <= acc_sum;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_binner.sv
// tb/tb_spike_binner.sv - self-checking bench for spike_binner
// Three instances share stimulus; a cycle-indexed window/refractory model predicts every output.
module tb_spike_binner;

  localparam int N    = 3;
  localparam int MAXC = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        spike_in;
  logic        stb [N];
  logic [15:0] cnt [N];
  logic        sat [N];

  int checks = 0;
  int errors = 0;

  int p_bin [N] = '{10, 10, 40};
  int p_ref [N] = '{3, 0, 0};

  bit sp_hist [0:65535];
  int base;
  int cyc;

  int start    [N];
  int last_acc [N];
  int win      [N];
  bit e_stb    [N];
  int e_cnt    [N];
  bit e_sat    [N];

  spike_binner #(.BIN_CYCLES(10), .REFRACT_CYCLES(3), .SYNC_STAGES(2), .COUNT_MAX(7)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
    .bin_strobe(stb[0]), .bin_count(cnt[0]), .bin_sat(sat[0])
  );

  spike_binner #(.BIN_CYCLES(10), .REFRACT_CYCLES(0), .SYNC_STAGES(2), .COUNT_MAX(7)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
    .bin_strobe(stb[1]), .bin_count(cnt[1]), .bin_sat(sat[1])
  );

  spike_binner #(.BIN_CYCLES(40), .REFRACT_CYCLES(0), .SYNC_STAGES(2), .COUNT_MAX(7)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
    .bin_strobe(stb[2]), .bin_count(cnt[2]), .bin_sat(sat[2])
  );

  always #5 clk = ~clk;

  function automatic bit sp_at(int k);
    return (k < base) ? 1'b0 : sp_hist[k];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    base = cyc;
    for (int i = 0; i < N; i++) begin
      start[i]    = -1;
      last_acc[i] = -1;
      win[i]      = 0;
      e_stb[i]    = 1'b0;
      e_cnt[i]    = 0;
      e_sat[i]    = 1'b0;
    end
  endtask

  // A spike sampled at cycle k is acted on at cycle k+2 (two sync flops).
  task automatic model_step(bit en);
    int n;
    bit e;
    int wpos;
    n = cyc;
    e = sp_at(n - 2) && !sp_at(n - 3);
    for (int i = 0; i < N; i++) begin
      e_stb[i] = 1'b0;
      if (start[i] >= 0) begin
        wpos = (n - start[i]) % p_bin[i];
        if (e && (last_acc[i] < 0 || n - last_acc[i] > p_ref[i])) begin
          last_acc[i] = n;
          win[i]++;
        end
        if (wpos == p_bin[i] - 1) begin
          e_stb[i] = 1'b1;
          e_cnt[i] = (win[i] > MAXC) ? MAXC : win[i];
          e_sat[i] = (win[i] > MAXC);
          win[i]   = 0;
          if (!en) begin
            start[i]    = -1;
            last_acc[i] = -1;
          end
        end else if (!en) begin
          start[i]    = -1;
          last_acc[i] = -1;
          win[i]      = 0;
        end
      end else if (en) begin
        start[i]    = n + 1;
        last_acc[i] = -1;
        win[i]      = 0;
      end
    end
  endtask

  task automatic step(bit en, bit sp);
    @(negedge clk);
    enable   = en;
    spike_in = sp;
    @(posedge clk);
    sp_hist[cyc] = sp;
    model_step(en);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("strobe%0d@%0d", i, cyc), {31'd0, stb[i]}, {31'd0, e_stb[i]});
      check($sformatf("count%0d@%0d", i, cyc), {16'd0, cnt[i]}, e_cnt[i]);
      check($sformatf("sat%0d@%0d", i, cyc), {31'd0, sat[i]}, {31'd0, e_sat[i]});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    enable   = 1'b0;
    spike_in = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_strobe%0d", i), {31'd0, stb[i]}, 32'd0);
      check($sformatf("rst_count%0d", i), {16'd0, cnt[i]}, 32'd0);
      check($sformatf("rst_sat%0d", i), {31'd0, sat[i]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    model_reset();
  endtask

  // Run idle cycles until the edge of the next-driven spike lands at window position target.
  task automatic align(int target);
    for (int k = 0; k < 60 && ((cyc + 2 - start[0]) % p_bin[0]) != target; k++) begin
      step(1'b1, 1'b0);
    end
  endtask

  initial begin
    bit en_r;
    bit sp_r;
    rst      = 1'b0;
    enable   = 1'b0;
    spike_in = 1'b0;
    cyc      = 0;
    model_reset();

    do_reset();

    // Idle windows: strobes with zero counts
    repeat (31) step(1'b1, 1'b0);

    // Isolated spikes inside one window
    align(0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);
    end
    repeat (20) step(1'b1, 1'b0);

    // Held-high spike gives one edge; close pair hits the lockout
    align(1);
    repeat (8) step(1'b1, 1'b1);
    repeat (12) step(1'b1, 1'b0);
    align(1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0);

    // Edge on the closing cycle
    align(9);
    step(1'b1, 1'b1);
    repeat (25) step(1'b1, 1'b0);

    // Toggle every other cycle: saturates the long window
    align(0);
    repeat (80) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    repeat (90) step(1'b1, 1'b0);

    // Enable drop mid-window discards the partial count
    align(0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int k = 0; k < 20 && ((cyc - start[0]) % p_bin[0]) != 5; k++) begin
      step(1'b1, 1'b0);
    end
    repeat (4) step(1'b0, 1'b0);
    repeat (25) step(1'b1, 1'b0);

    // Enable drop exactly on a closing cycle still strobes
    for (int k = 0; k < 20 && ((cyc - start[0]) % p_bin[0]) != 9; k++) begin
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // Randomized spikes and occasional enable drops
    en_r = 1'b1;
    sp_r = 1'b0;
    repeat (3000) begin
      if (en_r) en_r = ($urandom_range(0, 149) != 0);
      else      en_r = ($urandom_range(0, 9) == 0);
      sp_r = ($urandom_range(0, 99) < (sp_r ? 50 : 25));
      step(en_r, sp_r);
    end

    // Async reset in the middle of a busy window
    repeat (13) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    do_reset();
    repeat (25) step(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
